hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/riscv_pkg.sv | 7 +
 rtl/sat_counter.sv | 13 +
 rtl/hazard_ctrl.sv | 82 ++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared hazard FSM state encoding and forwarding select codes
package riscv_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MD_START = 2'd1, MD_BUSY = 2'd2} hz_state_t;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding control with multi-cycle muldiv wait
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ADDR-1:0] id_rs1,
  input  logic [REG_ADDR-1:0] id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [REG_ADDR-1:0] ex_rs1,
  input  logic [REG_ADDR-1:0] ex_rs2,
  input  logic [REG_ADDR-1:0] ex_rd,
  input  logic                ex_mem_read,
  input  logic                ex_is_muldiv,
  input  logic [REG_ADDR-1:0] mem_rd,
  input  logic                mem_reg_write,
  input  logic [1:0]          mem_branch_sel,
  input  logic [REG_ADDR-1:0] wb_rd,
  input  logic                wb_reg_write,
  input  logic                muldiv_done,
  output logic                pc_load,
  output logic                if_id_load,
  output logic                id_ex_load,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                ex_mem_flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                muldiv_start,
  output logic                muldiv_abort,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  hz_state_t state, state_nxt;
  logic redirect, load_use, busy, md_hold, lu_stall, rd_act;
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR-1:0] rs,
    input logic [REG_ADDR-1:0] m_rd,
    input logic                m_we,
    input logic [REG_ADDR-1:0] w_rd,
    input logic                w_we
  );
    return (m_we && m_rd != '0 && m_rd == rs) ? FWD_EXMEM :
           (w_we && w_rd != '0 && w_rd == rs) ? FWD_MEMWB : FWD_RF;
  endfunction
  assign redirect = |mem_branch_sel;
  assign load_use = ex_mem_read && ex_rd != '0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign busy     = state != RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = (redirect || (state == MD_BUSY && muldiv_done)) ? RUN :
                (state == MD_START) ? MD_BUSY :
                (state == RUN && ex_is_muldiv) ? MD_START : state;
  always_comb begin
    rd_act       = !rst && redirect;
    md_hold      = !rst && !redirect && busy && !(state == MD_BUSY && muldiv_done);
    lu_stall     = !rst && !redirect && !busy && !ex_is_muldiv && load_use;
    pc_load      = !(md_hold || lu_stall);
    if_id_load   = !(md_hold || lu_stall);
    id_ex_load   = !md_hold;
    if_id_flush  = rd_act;
    id_ex_flush  = rd_act || lu_stall;
    ex_mem_flush = rd_act || md_hold;
    muldiv_start = !rst && !redirect && !busy && ex_is_muldiv;
    muldiv_abort = rd_act && busy;
    fwd_a        = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b        = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(!pc_load && !redirect), .count(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(redirect), .count(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int RA  = 5;
  localparam int CW  = 4;
  localparam int SAT = 15;
  logic clk = 1'b0;
  logic rst;
  logic [RA-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_muldiv, mem_reg_write, wb_reg_write, muldiv_done;
  logic [1:0] mem_branch_sel;
  logic pc_load, if_id_load, id_ex_load, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_start, muldiv_abort;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int errors = 0;
  int checks = 0;
  int m, nm, sc, fc, n;
  logic e_pc, e_ifid, e_idex, e_fif, e_fidex, e_fexm, e_st, e_ab;
  always #5 clk = ~clk;
  hazard_ctrl #(.REG_ADDR(RA), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_muldiv(ex_is_muldiv),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_branch_sel(mem_branch_sel),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .muldiv_done(muldiv_done),
    .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .muldiv_start(muldiv_start), .muldiv_abort(muldiv_abort),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [1:0] fwd_ref(input logic [RA-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction
  task automatic model_out();
    bit red, lu;
    red = mem_branch_sel != 0;
    lu  = ex_mem_read && ex_rd != 0 &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    {e_pc, e_ifid, e_idex} = 3'b111;
    {e_fif, e_fidex, e_fexm, e_st, e_ab} = 5'b0;
    nm = m;
    if (rst) nm = 0;
    else if (red) begin
      {e_fif, e_fidex, e_fexm} = 3'b111;
      e_ab = (m != 0);
      nm = 0;
    end else if (m == 0) begin
      if (ex_is_muldiv) begin
        e_st = 1;
        nm = 1;
      end else if (lu) begin
        e_pc = 0;
        e_ifid = 0;
        e_fidex = 1;
      end
    end else if (m == 2 && muldiv_done) nm = 0;
    else begin
      {e_pc, e_ifid, e_idex} = 3'b000;
      e_fexm = 1;
      nm = 2;
    end
  endtask
  task automatic cyc();
    if (rst) begin m = 0; sc = 0; fc = 0; end
    @(negedge clk);
    model_out();
    chk("pc_load", pc_load, e_pc);
    chk("if_id_load", if_id_load, e_ifid);
    chk("id_ex_load", id_ex_load, e_idex);
    chk("if_id_flush", if_id_flush, e_fif);
    chk("id_ex_flush", id_ex_flush, e_fidex);
    chk("ex_mem_flush", ex_mem_flush, e_fexm);
    chk("muldiv_start", muldiv_start, e_st);
    chk("muldiv_abort", muldiv_abort, e_ab);
    chk("fwd_a", fwd_a, fwd_ref(ex_rs1));
    chk("fwd_b", fwd_b, fwd_ref(ex_rs2));
    chk("stall_cnt", stall_cnt, sc);
    chk("flush_cnt", flush_cnt, fc);
    @(posedge clk);
    if (rst) begin m = 0; sc = 0; fc = 0; end
    else begin
      if (!e_pc && mem_branch_sel == 0) sc = (sc < SAT) ? sc + 1 : SAT;
      if (mem_branch_sel != 0) fc = (fc < SAT) ? fc + 1 : SAT;
      m = nm;
    end
    #1;
  endtask
  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_muldiv, mem_reg_write, wb_reg_write, muldiv_done} = '0;
    mem_branch_sel = 2'b00;
  endtask
  task automatic set_lu();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
  endtask
  initial begin
    idle();
    rst = 1;
    m = 0; sc = 0; fc = 0;
    mem_branch_sel = 2'b01;
    #1;
    chk("rst_pc_load", pc_load, 1);
    chk("rst_flush", {if_id_flush, id_ex_flush, ex_mem_flush}, 0);
    chk("rst_abort", muldiv_abort, 0);
    cyc();
    idle();
    cyc();
    rst = 0;
    cyc();
    set_lu();
    #1;
    chk("lu_pc_load", pc_load, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    cyc();
    idle();
    chk("lu_stall_cnt", stall_cnt, 1);
    cyc();
    ex_rs1 = 7; mem_rd = 7; mem_reg_write = 1; wb_rd = 7; wb_reg_write = 1;
    #1 chk("fwd_exmem", fwd_a, 2'b01);
    mem_rd = 0;
    #1 chk("fwd_memwb", fwd_a, 2'b10);
    ex_rs1 = 0;
    #1 chk("fwd_rf", fwd_a, 2'b00);
    cyc();
    idle();
    ex_is_muldiv = 1;
    #1 chk("md_start", muldiv_start, 1);
    cyc();
    ex_is_muldiv = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (!pc_load) n++;
      cyc();
    end
    muldiv_done = 1;
    #1 chk("md_done_pc_load", pc_load, 1);
    cyc();
    muldiv_done = 0;
    chk("md_stall_cycles", n, 5);
    chk("md_stall_cnt", stall_cnt, 6);
    #1 chk("md_back_run", muldiv_start, 0);
    ex_is_muldiv = 1;
    cyc();
    ex_is_muldiv = 0;
    cyc();
    cyc();
    mem_branch_sel = 2'b01;
    #1;
    chk("rd_abort", muldiv_abort, 1);
    chk("rd_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
    chk("rd_pc_load", pc_load, 1);
    cyc();
    mem_branch_sel = 2'b00;
    #1;
    chk("rd_flush_cnt", flush_cnt, 1);
    chk("rd_to_run", pc_load, 1);
    cyc();
    set_lu();
    mem_branch_sel = 2'b10;
    #1;
    chk("rd_lu_pc_load", pc_load, 1);
    chk("rd_lu_flush", id_ex_flush, 1);
    cyc();
    chk("rd_lu_stall_cnt", stall_cnt, 8);
    chk("rd_lu_flush_cnt", flush_cnt, 2);
    mem_branch_sel = 2'b00;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_stall_cnt", stall_cnt, 15);
    idle();
    ex_is_muldiv = 1;
    cyc();
    ex_is_muldiv = 0;
    cyc();
    cyc();
    #2;
    rst = 1;
    mem_branch_sel = 2'b01;
    #1;
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
    chk("arst_abort", muldiv_abort, 0);
    chk("arst_pc_load", pc_load, 1);
    cyc();
    rst = 0;
    idle();
    #1 chk("arst_run", pc_load, 1);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      id_rs1 = RA'($urandom_range(0, 3));
      id_rs2 = RA'($urandom_range(0, 3));
      ex_rs1 = RA'($urandom_range(0, 3));
      ex_rs2 = RA'($urandom_range(0, 3));
      ex_rd  = RA'($urandom_range(0, 3));
      mem_rd = RA'($urandom_range(0, 3));
      wb_rd  = RA'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom);
      id_uses_rs2 = 1'($urandom);
      ex_mem_read = 1'($urandom);
      ex_is_muldiv = ($urandom_range(0, 5) == 0);
      mem_reg_write = 1'($urandom);
      wb_reg_write = 1'($urandom);
      muldiv_done = ($urandom_range(0, 2) == 0);
      mem_branch_sel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
